// File: rtl/pc_sequencer_pkg.sv
// Shared widths, FSM state encoding and jump-table targets for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int PC_W  = 9;
    localparam int CNT_W = 16;

    localparam int JT_IDX_W   = 4;
    localparam int JT_ENTRIES = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [PC_W-1:0] JT_TGT_0  = 9'd27;
    localparam logic [PC_W-1:0] JT_TGT_1  = 9'd34;
    localparam logic [PC_W-1:0] JT_TGT_2  = 9'd39;
    localparam logic [PC_W-1:0] JT_TGT_3  = 9'd53;
    localparam logic [PC_W-1:0] JT_TGT_4  = 9'd58;
    localparam logic [PC_W-1:0] JT_TGT_5  = 9'd61;
    localparam logic [PC_W-1:0] JT_TGT_6  = 9'd66;
    localparam logic [PC_W-1:0] JT_TGT_7  = 9'd112;
    localparam logic [PC_W-1:0] JT_TGT_8  = 9'd123;
    localparam logic [PC_W-1:0] JT_TGT_9  = 9'd128;
    localparam logic [PC_W-1:0] JT_TGT_10 = 9'd131;
    localparam logic [PC_W-1:0] JT_TGT_11 = 9'd136;
    localparam logic [PC_W-1:0] JT_TGT_12 = 9'd171;

endpackage

// File: rtl/pc_sequencer_jump_lut.sv
// Combinational jump table: maps a branch index to its target address and flags unmapped indices.
module jump_lut #(
    parameter int PC_W = pc_sequencer_pkg::PC_W
) (
    input  logic [pc_sequencer_pkg::JT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]                       target,
    output logic                                  valid
);
    import pc_sequencer_pkg::*;

    always_comb begin
        target = '0;
        valid  = 1'b1;
        case (idx)
            4'd0:    target = PC_W'(JT_TGT_0);
            4'd1:    target = PC_W'(JT_TGT_1);
            4'd2:    target = PC_W'(JT_TGT_2);
            4'd3:    target = PC_W'(JT_TGT_3);
            4'd4:    target = PC_W'(JT_TGT_4);
            4'd5:    target = PC_W'(JT_TGT_5);
            4'd6:    target = PC_W'(JT_TGT_6);
            4'd7:    target = PC_W'(JT_TGT_7);
            4'd8:    target = PC_W'(JT_TGT_8);
            4'd9:    target = PC_W'(JT_TGT_9);
            4'd10:   target = PC_W'(JT_TGT_10);
            4'd11:   target = PC_W'(JT_TGT_11);
            4'd12:   target = PC_W'(JT_TGT_12);
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps an instruction address through a program with halt, stall and table jumps.
//
//   state | meaning
//   IDLE  | waiting for Start, PC parked at 0
//   RUN   | program executing, PC advances per Halt > Stall > taken branch > increment
//   DONE  | program halted, outputs frozen until a new Start
module pc_sequencer #(
    parameter int PC_W  = pc_sequencer_pkg::PC_W,
    parameter int CNT_W = pc_sequencer_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic [3:0]       JumpIdx,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic             BadIdx,
    output logic [CNT_W-1:0] CycleCnt
);
    import pc_sequencer_pkg::*;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             bad_idx_q, bad_idx_d;

    logic [PC_W-1:0]  jump_target;
    logic             jump_valid;
    logic [PC_W-1:0]  pc_inc;
    logic [CNT_W-1:0] cnt_inc;

    jump_lut #(.PC_W(PC_W)) u_jump_lut (
        .idx    (JumpIdx),
        .target (jump_target),
        .valid  (jump_valid)
    );

    assign pc_inc  = pc_q + PC_W'(1);
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        bad_idx_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // The halt cycle is itself a RUN cycle, so it is counted.
                cnt_d = cnt_inc;
                if (Halt) begin
                    state_d = ST_DONE;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (BranchEn && Taken) begin
                    if (jump_valid) begin
                        pc_d = jump_target;
                    end else begin
                        pc_d      = pc_inc;
                        bad_idx_d = 1'b1;
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            bad_idx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
            bad_idx_q <= bad_idx_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign BadIdx   = bad_idx_q;
    assign CycleCnt = cnt_q;

endmodule
